fxp_alu_responder: RTL and testbench

//  Sequential, handshaked responder for sign-magnitude fixed-point ADD/MUL,

---
 rtl/fxp_pkg.sv | 35 +++
 rtl/fxp_seq_mul.sv | 64 ++++++
 rtl/fxp_alu_responder.sv | 238 +++++++++++++++++++++++
 tb/tb_fxp_alu_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fxp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fxp_pkg
//  Brief    : Shared defaults, opcode type, FSM state codes and flag bit
//             positions for the sign-magnitude fixed-point responder.
//  Revision : 1.0  initial release
// ============================================================================
package fxp_pkg;

    // Default word format: Q7.8 sign-magnitude (1 sign, 7 int, 8 frac bits)
    localparam int FXP_WIDTH  = 16;
    localparam int FXP_FRAC_W = 8;

    // Operation select, same encoding as the combinational ALU control bit
    typedef enum logic {
        OP_ADD = 1'b0,
        OP_MUL = 1'b1
    } fxp_op_e;

    // Responder FSM state encoding
    typedef logic [2:0] fxp_state_t;
    localparam fxp_state_t ST_IDLE = 3'd0;
    localparam fxp_state_t ST_ADD  = 3'd1;
    localparam fxp_state_t ST_MUL  = 3'd2;
    localparam fxp_state_t ST_NORM = 3'd3;
    localparam fxp_state_t ST_DONE = 3'd4;

    // Bit positions inside the 4-bit flag word {N, Z, C, V}
    localparam int FLG_N = 3;
    localparam int FLG_Z = 2;
    localparam int FLG_C = 1;
    localparam int FLG_V = 0;

endpackage : fxp_pkg
`default_nettype wire

// File: rtl/fxp_seq_mul.sv
`default_nettype none
// ============================================================================
//  Module   : fxp_seq_mul
//  Brief    : Iterative unsigned MAG_W x MAG_W shift-add multiplier. One
//             multiplier bit is consumed per cycle, LSB first. Operands are
//             loaded on 'start'; 'done' is high during the cycle whose clock
//             edge completes the last iteration, so 'product' is valid from
//             the following cycle until the next 'start'.
//  Revision : 1.0  initial release
// ============================================================================
module fxp_seq_mul #(
    parameter int MAG_W = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [MAG_W-1:0]     a,
    input  logic [MAG_W-1:0]     b,
    output logic                 done,
    output logic [2*MAG_W-1:0]   product
);

    localparam int                CNT_W     = $clog2(MAG_W + 1);
    localparam logic [CNT_W-1:0]  LAST_ITER = CNT_W'(MAG_W - 1);

    logic                 r_busy;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*MAG_W-1:0]   r_mcand;
    logic [MAG_W-1:0]     r_mplier;
    logic [2*MAG_W-1:0]   r_acc;

    // Load operands on start, then add the shifted multiplicand for each set
    // multiplier bit; the multiplicand walks left as the multiplier walks right.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_mcand  <= {{MAG_W{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
        end else if (r_busy) begin
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_ITER) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign done    = r_busy && (r_cnt == LAST_ITER);
    assign product = r_acc;

endmodule : fxp_seq_mul
`default_nettype wire

// File: rtl/fxp_alu_responder.sv
`default_nettype none
// ============================================================================
//  Module   : fxp_alu_responder
//  Brief    : Handshaked sign-magnitude fixed-point ADD/MUL responder. Takes
//             one request over valid/ready, computes it (ADD in one cycle,
//             MUL through an iterative shift-add multiplier plus a
//             normalisation cycle) and holds result and flags {N,Z,C,V}
//             until the consumer accepts them.
//  Revision : 1.0  initial release
// ============================================================================
module fxp_alu_responder
    import fxp_pkg::*;
#(
    parameter int WIDTH  = FXP_WIDTH,
    parameter int FRAC_W = FXP_FRAC_W   // must satisfy 1 <= FRAC_W < WIDTH-1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_op,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WIDTH-1:0]   res_data,
    output logic [3:0]         res_flags
);

    localparam int               MAG_W   = WIDTH - 1;
    localparam int               PROD_W  = 2 * MAG_W;
    localparam logic [MAG_W-1:0] MAG_MAX = {MAG_W{1'b1}};

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    fxp_state_t          r_state;
    fxp_op_e             r_op;
    logic                r_sa;
    logic                r_sb;
    logic [MAG_W-1:0]    r_ma;
    logic [MAG_W-1:0]    r_mb;
    logic                r_res_valid;
    logic [WIDTH-1:0]    r_res_data;
    logic [3:0]          r_res_flags;

    // ------------------------------------------------------------------
    // Request side: a -0 operand is folded to +0 at capture time
    // ------------------------------------------------------------------
    logic                w_accept;
    logic                w_mul_start;
    logic [MAG_W-1:0]    w_req_ma;
    logic [MAG_W-1:0]    w_req_mb;
    logic                w_req_sa;
    logic                w_req_sb;

    assign req_ready   = (r_state == ST_IDLE) && !rst;
    assign w_accept    = req_valid && req_ready;
    assign w_mul_start = w_accept && (req_op == OP_MUL);
    assign w_req_ma    = req_a[MAG_W-1:0];
    assign w_req_mb    = req_b[MAG_W-1:0];
    assign w_req_sa    = req_a[WIDTH-1] && (w_req_ma != '0);
    assign w_req_sb    = req_b[WIDTH-1] && (w_req_mb != '0);

    // ------------------------------------------------------------------
    // Magnitude multiplier, started straight from the request so that the
    // first iteration happens on the edge after acceptance
    // ------------------------------------------------------------------
    logic                w_mul_done;
    logic [PROD_W-1:0]   w_product;

    fxp_seq_mul #(
        .MAG_W   (MAG_W)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (w_mul_start),
        .a       (w_req_ma),
        .b       (w_req_mb),
        .done    (w_mul_done),
        .product (w_product)
    );

    // ------------------------------------------------------------------
    // Add path
    // ------------------------------------------------------------------
    logic [MAG_W:0]      w_sum;
    logic [MAG_W-1:0]    w_add_mag;
    logic                w_add_sign;
    logic                w_add_c;
    logic                w_add_v;

    assign w_sum = {1'b0, r_ma} + {1'b0, r_mb};

    // Like signs add with saturation on carry; unlike signs subtract the
    // smaller magnitude from the larger and take the larger's sign.
    always_comb begin
        w_add_mag  = '0;
        w_add_sign = 1'b0;
        w_add_c    = 1'b0;
        w_add_v    = 1'b0;
        if (r_sa == r_sb) begin
            w_add_sign = r_sa;
            if (w_sum[MAG_W]) begin
                w_add_mag = MAG_MAX;
                w_add_c   = 1'b1;
                w_add_v   = 1'b1;
            end else begin
                w_add_mag = w_sum[MAG_W-1:0];
            end
        end else if (r_ma >= r_mb) begin
            w_add_mag  = r_ma - r_mb;
            w_add_sign = r_sa;
        end else begin
            w_add_mag  = r_mb - r_ma;
            w_add_sign = r_sb;
        end
    end

    // ------------------------------------------------------------------
    // Multiply normalisation: truncate FRAC_W fraction bits, flag inexact
    // results on C and saturate anything that no longer fits the magnitude
    // ------------------------------------------------------------------
    logic [MAG_W-1:0]    w_mul_mag;
    logic                w_mul_c;
    logic                w_mul_v;

    // Select the kept window of the product and apply saturation.
    always_comb begin
        w_mul_c = |w_product[FRAC_W-1:0];
        w_mul_v = |w_product[PROD_W-1:MAG_W+FRAC_W];
        if (w_mul_v) begin
            w_mul_mag = MAG_MAX;
        end else begin
            w_mul_mag = w_product[MAG_W+FRAC_W-1:FRAC_W];
        end
    end

    // ------------------------------------------------------------------
    // Result formatting shared by both paths
    // ------------------------------------------------------------------
    logic [MAG_W-1:0]    w_sel_mag;
    logic                w_sel_sign;
    logic                w_sel_c;
    logic                w_sel_v;
    logic                w_zero;
    logic                w_sign;
    logic [WIDTH-1:0]    w_res_data;
    logic [3:0]          w_res_flags;

    // Pick the active path, then suppress -0 and assemble {N,Z,C,V}.
    always_comb begin
        if (r_op == OP_MUL) begin
            w_sel_mag  = w_mul_mag;
            w_sel_sign = r_sa ^ r_sb;
            w_sel_c    = w_mul_c;
            w_sel_v    = w_mul_v;
        end else begin
            w_sel_mag  = w_add_mag;
            w_sel_sign = w_add_sign;
            w_sel_c    = w_add_c;
            w_sel_v    = w_add_v;
        end
        w_zero                 = (w_sel_mag == '0);
        w_sign                 = w_sel_sign && !w_zero;
        w_res_data             = {w_sign, w_sel_mag};
        w_res_flags            = '0;
        w_res_flags[FLG_N]     = w_sign;
        w_res_flags[FLG_Z]     = w_zero;
        w_res_flags[FLG_C]     = w_sel_c;
        w_res_flags[FLG_V]     = w_sel_v;
    end

    // ------------------------------------------------------------------
    // Control FSM, operand capture and result holding registers
    // ------------------------------------------------------------------
    // Sequence IDLE -> ADD|MUL(->NORM) -> DONE -> IDLE; result registers
    // load only on entry to DONE so they stay frozen under back-pressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_ADD;
            r_sa        <= 1'b0;
            r_sb        <= 1'b0;
            r_ma        <= '0;
            r_mb        <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_flags <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op <= fxp_op_e'(req_op);
                        r_sa <= w_req_sa;
                        r_sb <= w_req_sb;
                        r_ma <= w_req_ma;
                        r_mb <= w_req_mb;
                        r_state <= (req_op == OP_MUL) ? ST_MUL : ST_ADD;
                    end
                end
                ST_ADD: begin
                    r_res_data  <= w_res_data;
                    r_res_flags <= w_res_flags;
                    r_res_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_MUL: begin
                    if (w_mul_done) begin
                        r_state <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    r_res_data  <= w_res_data;
                    r_res_flags <= w_res_flags;
                    r_res_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_res_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_flags = r_res_flags;

endmodule : fxp_alu_responder
`default_nettype wire

// File: tb/tb_fxp_alu_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fxp_alu_responder
//  Brief    : Self-checking bench for fxp_alu_responder (Q7.8 default).
//             Directed cases plus randomized traffic against a signed
//             arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fxp_alu_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [3:0]  res_flags;

    int n_vec = 0;
    int n_err = 0;

    fxp_alu_responder dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_flags (res_flags)
    );

    always #5 clk = ~clk;

    // Reference: interpret operands as signed Q7.8 values and apply the
    // arithmetic rules directly. Returns {data[15:0], flags[3:0]}.
    function automatic logic [19:0] model(input logic op, input logic [15:0] a, input logic [15:0] b);
        longint ma, mb, va, vb, s, p, pm, mag;
        logic   neg, c, v;
        ma  = longint'(a[14:0]);
        mb  = longint'(b[14:0]);
        va  = a[15] ? -ma : ma;
        vb  = b[15] ? -mb : mb;
        c   = 1'b0;
        v   = 1'b0;
        if (op == 1'b0) begin
            s   = va + vb;
            neg = (s < 0);
            mag = neg ? -s : s;
            if (mag > 32767) begin
                mag = 32767;
                c   = 1'b1;
                v   = 1'b1;
            end
        end else begin
            p   = va * vb;
            pm  = ma * mb;
            neg = (p < 0);
            c   = ((pm % 256) != 0);
            mag = pm / 256;
            if (mag > 32767) begin
                mag = 32767;
                v   = 1'b1;
            end
        end
        if (mag == 0) neg = 1'b0;
        return {neg, 15'(mag), neg, (mag == 0), c, v};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request and return just after the edge that accepted it.
    task automatic accept_op(input logic op, input logic [15:0] a, input logic [15:0] b);
        int w;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        w = 0;
        while (req_ready !== 1'b1 && w < 64) begin
            @(posedge clk); #1;
            w++;
        end
        check("accept_wait_ok", 32'(w < 64), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = 1'($urandom);
        req_a     = 16'($urandom);
        req_b     = 16'($urandom);
    endtask

    // Full transaction: accept, measure latency, check result, hold it for
    // 'hold' cycles (optionally with the next request already pending), then
    // transfer it and check the return to IDLE.
    task automatic run_op(input string tag, input logic op, input logic [15:0] a, input logic [15:0] b,
                          input int hold, input logic preload, input logic pop,
                          input logic [15:0] pa, input logic [15:0] pb);
        logic [19:0] exp;
        int lat;
        exp = model(op, a, b);
        accept_op(op, a, b);
        lat = 0;
        while (res_valid !== 1'b1 && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), op ? 32'd16 : 32'd1);
        check({tag, "_data"},    32'(res_data),  32'(exp[19:4]));
        check({tag, "_flags"},   32'(res_flags), 32'(exp[3:0]));
        if (preload) begin
            req_op    = pop;
            req_a     = pa;
            req_b     = pb;
            req_valid = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold"}, {12'd0, res_valid, req_ready, res_data, res_flags},
                  {12'd0, 1'b1, 1'b0, exp});
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check({tag, "_xfer"}, {30'd0, res_valid, req_ready}, 32'd1);
    endtask

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 9))
            0:       return 16'h0000;
            1:       return 16'h8000;
            2:       return 16'h7FFF;
            3:       return 16'hFFFF;
            4:       return 16'h0100;
            5:       return 16'h8100;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic       stale;
        logic       rop;
        logic [15:0] ra, rb;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 1'b0;
        req_a     = 16'h0;
        req_b     = 16'h0;
        res_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data",  32'(res_data),  32'd0);
        check("rst_res_flags", 32'(res_flags), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_req_ready", 32'(req_ready), 32'd1);

        // Basic ADD and MUL
        run_op("add_basic", 1'b0, 16'h0180, 16'h0280, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        run_op("mul_basic", 1'b1, 16'h0180, 16'h0280, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        run_op("mul_neg",   1'b1, 16'h8180, 16'h0280, 0, 1'b0, 1'b0, 16'h0, 16'h0);

        // Cancellation and saturation boundaries
        run_op("add_cancel", 1'b0, 16'h8180, 16'h0180, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        run_op("add_sat",    1'b0, 16'h7F00, 16'h0200, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        run_op("mul_sat",    1'b1, 16'h4000, 16'h0400, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        run_op("mul_inexact",1'b1, 16'h0001, 16'h0001, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        run_op("add_negzero",1'b0, 16'h8000, 16'h8005, 0, 1'b0, 1'b0, 16'h0, 16'h0);

        // Back-pressure with a second request already waiting
        run_op("bp_first",  1'b0, 16'h0300, 16'h8100, 5, 1'b1, 1'b1, 16'h0200, 16'h8300);
        run_op("bp_second", 1'b1, 16'h0200, 16'h8300, 0, 1'b0, 1'b0, 16'h0, 16'h0);

        // Reset in the middle of a multiply abandons it
        accept_op(1'b1, 16'h0180, 16'h0280);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("midrst_res_valid", 32'(res_valid), 32'd0);
        rst = 1'b0;
        #1;
        check("midrst_idle", 32'(req_ready), 32'd1);
        stale = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (res_valid !== 1'b0) stale = 1'b1;
        end
        check("midrst_no_stale", 32'(stale), 32'd0);
        run_op("post_rst_add", 1'b0, 16'h0080, 16'h8200, 0, 1'b0, 1'b0, 16'h0, 16'h0);

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            rop = 1'($urandom);
            ra  = pick();
            rb  = pick();
            run_op("rand", rop, ra, rb, int'($urandom_range(0, 3)), 1'b0, 1'b0, 16'h0, 16'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout vectors=%0d", n_vec);
        $fatal(1, "simulation did not complete");
    end

endmodule : tb_fxp_alu_responder
`default_nettype wire
